// File: rtl/gaussian_filter_3x3.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gaussian_filter_3x3
// Description : 3x3 [1 2 1;2 4 2;1 2 1]/16 smoothing of an 8-bit video stream
// Revision    : 1.0 - initial release
// ============================================================================
module gaussian_filter_3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int ROW_W     = 10
) (
    input  logic       clk,
    input  logic       rst_s,
    input  logic [7:0] gray_in,
    input  logic       gray_de,
    input  logic       gray_hs,
    input  logic       gray_vs,
    output logic [7:0] filter_out,
    output logic       filter_de,
    output logic       filter_hs,
    output logic       filter_vs
);

    localparam logic [ROW_W-1:0] c_IMG_W = ROW_W'(IMG_WIDTH);
    localparam logic [ROW_W-1:0] c_TWO   = ROW_W'(2);

    logic [7:0]       r_lb0 [IMG_WIDTH];
    logic [7:0]       r_lb1 [IMG_WIDTH];
    logic [7:0]       r_win [3][3];
    logic [ROW_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_de_q;
    logic             r_border;
    logic             r_border_p;
    logic [10:0]      r_rs0;
    logic [10:0]      r_rs1;
    logic [10:0]      r_rs2;
    logic [7:0]       r_out;
    logic [2:0]       r_de_d;
    logic [2:0]       r_hs_d;
    logic [2:0]       r_vs_d;

    logic [7:0]       w_lb0_tap;
    logic [7:0]       w_lb1_tap;
    logic             w_eol;
    logic [10:0]      w_rs0;
    logic [9:0]       w_mid;
    logic [10:0]      w_rs2;
    logic [11:0]      w_sum;

    assign w_lb0_tap = r_lb0[IMG_WIDTH-1];
    assign w_lb1_tap = r_lb1[IMG_WIDTH-1];

    // A de drop only ends the line once a full line has been accepted, so
    // mid-line de gaps neither reset the column nor advance the row.
    assign w_eol = r_de_q && !gray_de && (r_col >= c_IMG_W);

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
        end else if (!gray_vs) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
        end else if (gray_de) begin
            for (int i = IMG_WIDTH-1; i > 0; i--) begin
                r_lb0[i] <= r_lb0[i-1];
                r_lb1[i] <= r_lb1[i-1];
            end
            r_lb0[0] <= gray_in;
            r_lb1[0] <= w_lb0_tap;
        end
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_border <= 1'b1;
        end else if (gray_de) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb1_tap;
            r_win[1][2] <= w_lb0_tap;
            r_win[2][2] <= gray_in;
            r_border    <= (r_row < c_TWO) || (r_col < c_TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_de_q <= 1'b0;
            r_col  <= '0;
            r_row  <= '0;
        end else begin
            r_de_q <= gray_de;
            if (!gray_vs) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_eol) begin
                r_col <= '0;
                if (r_row != '1) begin
                    r_row <= r_row + 1'b1;
                end
            end else if (gray_de) begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign w_rs0 = {3'b0, r_win[0][0]} + {2'b0, r_win[0][1], 1'b0} + {3'b0, r_win[0][2]};
    assign w_mid = {2'b0, r_win[1][0]} + {1'b0, r_win[1][1], 1'b0} + {2'b0, r_win[1][2]};
    assign w_rs2 = {3'b0, r_win[2][0]} + {2'b0, r_win[2][1], 1'b0} + {3'b0, r_win[2][2]};
    assign w_sum = {1'b0, r_rs0} + {1'b0, r_rs1} + {1'b0, r_rs2};

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_rs0      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_border_p <= 1'b1;
            r_out      <= '0;
            r_de_d     <= '0;
            r_hs_d     <= '0;
            r_vs_d     <= '0;
        end else begin
            r_rs0      <= w_rs0;
            r_rs1      <= {w_mid, 1'b0};
            r_rs2      <= w_rs2;
            r_border_p <= r_border;
            r_de_d     <= {r_de_d[1:0], gray_de};
            r_hs_d     <= {r_hs_d[1:0], gray_hs};
            r_vs_d     <= {r_vs_d[1:0], gray_vs};
            // Max sum 4080 + 8 still fits 12 bits, so no saturation is needed.
            if (r_border_p || !r_de_d[1]) begin
                r_out <= '0;
            end else begin
                r_out <= 8'((w_sum + 12'd8) >> 4);
            end
        end
    end

    assign filter_out = r_out;
    assign filter_de  = r_de_d[2];
    assign filter_hs  = r_hs_d[2];
    assign filter_vs  = r_vs_d[2];

endmodule
`default_nettype wire

// File: tb/tb_gaussian_filter_3x3.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gaussian_filter_3x3
// Description : directed-frame bench for gaussian_filter_3x3 (8x6 images)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gaussian_filter_3x3;

    localparam int c_W      = 8;
    localparam int c_H      = 6;
    localparam int c_K_FLAT = 0;
    localparam int c_K_IMP  = 1;
    localparam int c_K_ALL  = 2;
    localparam int c_K_RAMP = 3;

    logic       clk = 1'b0;
    logic       rst_s = 1'b0;
    logic [7:0] gray_in = '0;
    logic       gray_de = 1'b0;
    logic       gray_hs = 1'b0;
    logic       gray_vs = 1'b0;
    logic [7:0] filter_out;
    logic       filter_de;
    logic       filter_hs;
    logic       filter_vs;

    int         n_chk = 0;
    int         n_pass = 0;
    int         outq[$];
    logic [2:0] hist [3];
    int         hcnt = 0;

    gaussian_filter_3x3 #(.IMG_WIDTH(c_W), .ROW_W(10)) u_dut (
        .clk        (clk),
        .rst_s      (rst_s),
        .gray_in    (gray_in),
        .gray_de    (gray_de),
        .gray_hs    (gray_hs),
        .gray_vs    (gray_vs),
        .filter_out (filter_out),
        .filter_de  (filter_de),
        .filter_hs  (filter_hs),
        .filter_vs  (filter_vs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            c_K_FLAT: return 100;
            c_K_ALL:  return 255;
            c_K_RAMP: return c;
            default:  return (r == 3 && c == 4) ? 160 : 0;
        endcase
    endfunction

    // Output at input position (r,c) is centred on image pixel (r-1,c-1).
    function automatic int expv(input int kind, input int r, input int c);
        int dr, dc;
        if (r < 2 || c < 2) return 0;
        case (kind)
            c_K_FLAT: return 100;
            c_K_ALL:  return 255;
            c_K_RAMP: return c - 1;
            default: begin
                dr = (r > 4) ? r - 4 : 4 - r;
                dc = (c > 5) ? c - 5 : 5 - c;
                if (dr > 1 || dc > 1) return 0;
                if (dr == 0 && dc == 0) return 40;
                if (dr == 0 || dc == 0) return 20;
                return 10;
            end
        endcase
    endfunction

    // Output timing and sync path: every cycle against the inputs 3 clk earlier.
    always @(negedge clk) begin
        if (!rst_s) begin
            hcnt = 0;
        end else begin
            if (hcnt >= 3) begin
                check("de_dly", int'(filter_de), int'(hist[2][2]));
                check("hs_dly", int'(filter_hs), int'(hist[2][1]));
                check("vs_dly", int'(filter_vs), int'(hist[2][0]));
            end
            if (!filter_de) check("out_when_no_de", int'(filter_out), 0);
            else outq.push_back(int'(filter_out));
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {gray_de, gray_hs, gray_vs};
            hcnt++;
        end
    end

    task automatic drive(input logic de, input logic hs, input logic vs, input logic [7:0] px);
        @(posedge clk);
        #1;
        gray_de = de;
        gray_hs = hs;
        gray_vs = vs;
        gray_in = px;
    endtask

    task automatic send_frame(input int kind, input int gap_line, input int abort_line, input bit do_rst);
        for (int r = 0; r < c_H; r++) begin
            for (int h = 0; h < 4; h++) drive(1'b0, (h == 1 || h == 2), 1'b1, 8'd0);
            for (int c = 0; c < c_W; c++) begin
                if (r == gap_line && c == 4) repeat (5) drive(1'b0, 1'b0, 1'b1, 8'd0);
                if (r == abort_line && c == 6) begin
                    if (do_rst) begin
                        @(posedge clk);
                        #2 rst_s = 1'b0;
                        #1;
                        check("rst_mid_out", int'(filter_out), 0);
                        check("rst_mid_de", int'(filter_de), 0);
                        check("rst_mid_vs", int'(filter_vs), 0);
                        gray_de = 1'b0;
                        gray_hs = 1'b0;
                        gray_vs = 1'b0;
                        @(posedge clk);
                        #2 rst_s = 1'b1;
                    end
                    return;
                end
                drive(1'b1, 1'b0, 1'b1, 8'(pix(kind, r, c)));
            end
        end
        repeat (4) drive(1'b0, 1'b0, 1'b1, 8'd0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic verify_frame(input int kind, input string name);
        int n;
        check({name, "_count"}, outq.size(), c_W * c_H);
        n = (outq.size() < c_W * c_H) ? outq.size() : c_W * c_H;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_r%0d_c%0d", name, i / c_W, i % c_W),
                  outq[i], expv(kind, i / c_W, i % c_W));
        end
        outq.delete();
    endtask

    initial begin
        gray_de = 1'b1;
        gray_hs = 1'b1;
        gray_vs = 1'b1;
        gray_in = 8'd200;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", int'(filter_out), 0);
        check("reset_de", int'(filter_de), 0);
        check("reset_hs", int'(filter_hs), 0);
        check("reset_vs", int'(filter_vs), 0);
        @(posedge clk);
        #2;
        rst_s   = 1'b1;
        gray_de = 1'b0;
        gray_hs = 1'b0;
        gray_vs = 1'b0;
        gray_in = 8'd0;
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'd0);
        outq.delete();

        send_frame(c_K_FLAT, -1, -1, 1'b0);
        verify_frame(c_K_FLAT, "flat");
        send_frame(c_K_IMP, -1, -1, 1'b0);
        verify_frame(c_K_IMP, "impulse");
        send_frame(c_K_ALL, -1, -1, 1'b0);
        verify_frame(c_K_ALL, "white");
        send_frame(c_K_RAMP, 3, -1, 1'b0);
        verify_frame(c_K_RAMP, "ramp_gap");

        send_frame(c_K_ALL, -1, 3, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'd0);
        outq.delete();
        send_frame(c_K_IMP, -1, -1, 1'b0);
        verify_frame(c_K_IMP, "after_vs_drop");

        send_frame(c_K_ALL, -1, 3, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'd0);
        outq.delete();
        send_frame(c_K_IMP, -1, -1, 1'b0);
        verify_frame(c_K_IMP, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
